// File: rtl/uart_pkg.sv
// Shared definitions for the transmit-only UART: default word width and FSM states.
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BYTE_BITS  = 8;
  localparam int unsigned DIV_W      = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous word FIFO; full/empty are registered, head word is presented combinationally.
module uart_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  // A write while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    push_ok    = push && !full;
    pop_ok     = pop && !empty;
    count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/uart.sv
// Transmit-only UART: queues words and sends each as DATA_WIDTH/8 8N1 frames, LSB byte first.
module uart #(
  parameter int unsigned DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NTICKS     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [10:0]           divisor,
  output logic                  tx,
  output logic                  tx_full
);

  import uart_pkg::*;

  localparam int unsigned NBYTES = DATA_WIDTH / BYTE_BITS;
  localparam int unsigned TICK_W = (NTICKS > 1) ? $clog2(NTICKS) : 1;
  localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t                state, state_next;
  logic [DIV_W-1:0]      baud_cnt, baud_next, div_max_c;
  logic [TICK_W-1:0]     tick_cnt, tick_next;
  logic [2:0]            bit_cnt, bit_next;
  logic [BYTE_W-1:0]     byte_cnt, byte_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic [DATA_WIDTH-1:0] fifo_data_c;
  logic                  tx_next;
  logic                  tick_c;
  logic                  last_tick_c;
  logic                  fifo_pop_c;
  logic                  fifo_empty;

  uart_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wren),
    .pop       (fifo_pop_c),
    .wr_data   (w_data),
    .rd_data_c (fifo_data_c),
    .full      (tx_full),
    .empty     (fifo_empty)
  );

  // Baud tick: divisor 0 and 1 both mean one tick per cycle.
  always_comb begin
    div_max_c   = (divisor <= DIV_W'(1)) ? '0 : divisor - DIV_W'(1);
    tick_c      = (state != IDLE) && (baud_cnt == div_max_c);
    last_tick_c = tick_c && (tick_cnt == TICK_W'(NTICKS - 1));
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    byte_next  = byte_cnt;
    shreg_next = shreg;
    fifo_pop_c = 1'b0;
    tx_next    = 1'b1;

    if (state == IDLE) begin
      baud_next = '0;
    end else if (tick_c) begin
      baud_next = '0;
    end else begin
      baud_next = baud_cnt + DIV_W'(1);
    end

    if (tick_c) begin
      tick_next = last_tick_c ? '0 : tick_cnt + TICK_W'(1);
    end

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          shreg_next = fifo_data_c;
          byte_next  = '0;
          bit_next   = '0;
          tick_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (last_tick_c) begin
          bit_next   = '0;
          state_next = DATA;
        end
      end
      // Shifting the whole word leaves the next byte aligned at the LSB after eight bits.
      DATA: begin
        if (last_tick_c) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (last_tick_c) begin
          if (byte_cnt == BYTE_W'(NBYTES - 1)) begin
            state_next = IDLE;
          end else begin
            byte_next  = byte_cnt + BYTE_W'(1);
            state_next = START;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
      byte_cnt <= byte_next;
      shreg    <= shreg_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart.sv
// Directed self-checking bench for the transmit-only UART.
module tb_uart;

  logic        clk;
  logic        reset;
  logic        wren;
  logic [31:0] w_data;
  logic [10:0] divisor;
  logic        tx;
  logic        tx_full;

  int checks = 0;
  int errors = 0;

  uart dut (
    .clk     (clk),
    .reset   (reset),
    .wren    (wren),
    .w_data  (w_data),
    .divisor (divisor),
    .tx      (tx),
    .tx_full (tx_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // One-cycle write; returns at the falling edge just after the push edge.
  task automatic write_word(input logic [31:0] d);
    @(negedge clk);
    wren   = 1'b1;
    w_data = d;
    @(negedge clk);
    wren   = 1'b0;
  endtask

  // Follows a whole word on tx cycle by cycle; cycle 0 is the first start-bit cycle.
  task automatic check_word(input int bitlen, input logic [31:0] exp, input int first_cyc, input string tag);
    int   bad [4];
    int   byte_i;
    int   bit_i;
    logic eb;
    for (int i = 0; i < 4; i++) bad[i] = 0;
    for (int cyc = first_cyc; cyc < 40 * bitlen; cyc++) begin
      if (cyc != first_cyc) @(negedge clk);
      byte_i = cyc / (10 * bitlen);
      bit_i  = (cyc / bitlen) % 10;
      if (bit_i == 0)      eb = 1'b0;
      else if (bit_i == 9) eb = 1'b1;
      else                 eb = exp[byte_i * 8 + bit_i - 1];
      if (tx !== eb) bad[byte_i]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bad[i] !== 0) begin
        errors++;
        $display("FAIL %s byte%0d: %0d wrong tx cycles, required 0 (byte 0x%02h)", tag, i, bad[i], exp[i*8 +: 8]);
      end
    end
  endtask

  task automatic test_reset();
    int bad_tx = 0;
    int bad_full = 0;
    reset   = 1'b1;
    wren    = 1'b0;
    w_data  = '0;
    divisor = 11'd10;
    repeat (3) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (tx_full !== 1'b0) bad_full++;
    end
    reset = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (tx_full !== 1'b0) bad_full++;
    end
    checks++;
    if (bad_tx !== 0) begin
      errors++;
      $display("FAIL reset_tx: %0d cycles with tx!=1, required 0", bad_tx);
    end
    checks++;
    if (bad_full !== 0) begin
      errors++;
      $display("FAIL reset_full: %0d cycles with tx_full!=0, required 0", bad_full);
    end
  endtask

  task automatic test_single();
    int bad = 0;
    divisor = 11'd10;
    write_word(32'h5F0A3E1D);
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: tx=%b, required 0", tx);
    end
    check_word(160, 32'h5F0A3E1D, 0, "single");
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL single_idle: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    int full_seen = 0;
    int bad = 0;
    words[0] = 32'h5F0A3E1D;
    words[1] = 32'hF9E3A117;
    words[2] = 32'h13C5A27D;
    words[3] = 32'h27C00743;
    divisor = 11'd10;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wren   = 1'b1;
      w_data = words[i];
      @(negedge clk);
      if (tx_full !== 1'b0) full_seen++;
      if (i == 1) begin
        checks++;
        if (tx !== 1'b0) begin
          errors++;
          $display("FAIL burst_latency: tx=%b, required 0", tx);
        end
      end
    end
    wren = 1'b0;
    checks++;
    if (full_seen !== 0) begin
      errors++;
      $display("FAIL burst_full: tx_full high on %0d write cycles, required 0", full_seen);
    end
    check_word(160, words[0], 2, "burst w0");
    for (int w = 1; w < 4; w++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL burst_gap%0d: tx=%b, required 1", w, tx);
      end
      @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
        errors++;
        $display("FAIL burst_restart%0d: tx=%b, required 0", w, tx);
      end
      check_word(160, words[w], 0, $sformatf("burst w%0d", w));
    end
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL burst_idle: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ov [6];
    int bad = 0;
    ov[0] = 32'h01020304;
    ov[1] = 32'hA0B0C0D0;
    ov[2] = 32'h55AA55AA;
    ov[3] = 32'h80000001;
    ov[4] = 32'hDEADBEEF;
    ov[5] = 32'hCAFEF00D;
    divisor = 11'd1;
    write_word(32'h12345678);
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL ovf_latency: tx=%b, required 0", tx);
    end
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wren   = 1'b1;
          w_data = ov[i];
          @(negedge clk);
          if (i == 2) begin
            checks++;
            if (tx_full !== 1'b0) begin
              errors++;
              $display("FAIL ovf_full3: tx_full=%b, required 0", tx_full);
            end
          end
          if (i >= 3) begin
            checks++;
            if (tx_full !== 1'b1) begin
              errors++;
              $display("FAIL ovf_full%0d: tx_full=%b, required 1", i + 1, tx_full);
            end
          end
        end
        wren = 1'b0;
      end
      begin
        check_word(16, 32'h12345678, 0, "ovf w0");
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checks++;
          if (tx !== 1'b1) begin
            errors++;
            $display("FAIL ovf_gap%0d: tx=%b, required 1", k, tx);
          end
          if (k == 0) begin
            checks++;
            if (tx_full !== 1'b1) begin
              errors++;
              $display("FAIL ovf_full_before_pop: tx_full=%b, required 1", tx_full);
            end
          end
          @(negedge clk);
          checks++;
          if (tx !== 1'b0) begin
            errors++;
            $display("FAIL ovf_restart%0d: tx=%b, required 0", k, tx);
          end
          if (k == 0) begin
            checks++;
            if (tx_full !== 1'b0) begin
              errors++;
              $display("FAIL ovf_full_after_pop: tx_full=%b, required 0", tx_full);
            end
          end
          check_word(16, ov[k], 0, $sformatf("ovf w%0d", k + 1));
        end
      end
    join
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ovf_dropped: %0d non-idle cycles after 5 words, required 0", bad);
    end
  endtask

  task automatic test_divisor();
    int low = 1;
    for (int d = 0; d < 2; d++) begin
      divisor = 11'(d);
      write_word(32'hA5C3_0FF0);
      @(negedge clk);
      check_word(16, 32'hA5C3_0FF0, 0, $sformatf("div%0d", d));
      @(negedge clk);
    end
    divisor = 11'd2047;
    write_word(32'h0000_0001);
    @(negedge clk);
    for (int c = 0; c < 33000; c++) begin
      @(negedge clk);
      if (tx !== 1'b0) break;
      low++;
    end
    checks++;
    if (low !== 32752) begin
      errors++;
      $display("FAIL div2047_bit: start bit %0d cycles, required 32752", low);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL div2047_abort: tx=%b, required 1", tx);
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    divisor = 11'd1;
    write_word(32'h3C3C3C3C);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wren   = 1'b1;
      w_data = 32'hFFFF0000 + 32'(i);
      @(negedge clk);
    end
    wren = 1'b0;
    checks++;
    if (tx_full !== 1'b1) begin
      errors++;
      $display("FAIL midrst_full: tx_full=%b, required 1", tx_full);
    end
    // cycle 4 now; cycle 200 is data bit 1 of byte 1 (0x3C -> bit value 0)
    repeat (196) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: tx=%b, required 0", tx);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL midrst_tx: tx=%b, required 1", tx);
    end
    checks++;
    if (tx_full !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flush: tx_full=%b, required 0", tx_full);
    end
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: %0d non-idle cycles, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_divisor();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart.md
# uart

Transmit-only UART with a word-wide write FIFO. Accepts DATA_WIDTH-bit words from a bus-side writer, queues them, and serialises each word as DATA_WIDTH/8 standard 8N1 frames, least-significant byte first. Bit rate comes from a programmable clock divisor and NTICKS ticks per bit. It is the serial output stage of the APB-to-UART bridge.

## Interface
- DATA_WIDTH, 32: width of written words; must be a multiple of 8.
- FIFO_DEPTH, 4: number of words the FIFO holds; power of two, ≥2.
- NTICKS, 16: baud ticks per serial bit.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wren  in  1  write strobe; pushes w_data when FIFO is not full.
- w_data  in  DATA_WIDTH  word to transmit.
- divisor  in  11  clock cycles per baud tick.
- tx  out  1  serial line, idle high.
- tx_full  out  1  FIFO full flag.

## Operation
- FIFO: push when wren=1 and not full. Writes while full are dropped with no error. Pop is issued by the transmitter only. A push and a pop in the same cycle are both honoured if the FIFO is not full. Pointers wrap modulo FIFO_DEPTH. tx_full is high exactly when the count equals FIFO_DEPTH.
- Baud generator: 11-bit counter runs 0..max(divisor,1)-1. A one-cycle tick is issued when the counter equals max(divisor,1)-1. Divisor 0 or 1 gives a tick every cycle. The counter is held at 0 while in IDLE. A divisor change takes effect at the next compare.
- FSM states: IDLE, START, DATA, STOP. Counters:
  - tick counter, 0..NTICKS-1
  - bit counter, 0..7
  - byte counter, 0..DATA_WIDTH/8-1
- IDLE: tx=1. If the FIFO is non-empty: pop, load the word into the shift register, clear the byte counter, go to START.
- START: tx=0. After NTICKS ticks go to DATA.
- DATA: tx = current byte bit, LSB first. After each NTICKS ticks, shift and increment the bit counter. After bit 7 go to STOP.
- STOP: tx=1. After NTICKS ticks:
  - if this was not the last byte of the word: increment the byte counter and go to START;
  - otherwise go to IDLE.
- Byte order within a word: w_data[7:0] first, then [15:8], and so on up to the MSB byte.
- Reset:
  - FIFO is emptied and tx_full=0.
  - FSM goes to IDLE and tx=1.
  - All counters are cleared.
  - Reset mid-frame aborts the frame immediately.
  - Queued words are discarded.

## Timing
- tx is registered.
- A word written at edge k into an empty FIFO with the FSM in IDLE:
  - is popped at edge k+1;
  - tx falls after edge k+1.
- Each bit lasts exactly NTICKS·max(divisor,1) clock cycles.
- Frame = 10 bits; word = 10·DATA_WIDTH/8 bits.
- Consecutive bytes of a word are back-to-back, with no extra idle.
- Between words, one IDLE cycle (tx=1) is inserted before the next pop.
- tx_full rises the cycle after the push that fills the FIFO. It falls the cycle after a pop.

## Structure
- The shared package holds DATA_WIDTH and the FSM state enum (IDLE, START, DATA, STOP).
- Sub-module uart_fifo (synchronous FIFO: push/pop/full/empty/read data), parameterised by width and depth.
- The baud generator and FSM are inline in uart.

## Test plan
- Reset: hold reset 3 cycles, then release. Required response: tx=1 and tx_full=0 throughout, with no transitions for 1000 cycles with wren=0.
- Single word, divisor=10: write 0x5F0A3E1D.
  - First frame: start 0, then bits 1,0,1,1,1,0,0,0 (0x1D LSB first), then stop 1, each bit 160 cycles.
  - Then frames 0x3E, 0x0A, 0x5F follow back-to-back.
  - Total 6400 cycles of activity.
- Burst to full: write 0x5F0A3E1D, 0xF9E3A117, 0x13C5A27D, 0x27C00743 on four consecutive cycles.
  - Words are transmitted in order, bytes LSB-first.
  - Idle is reached about 25,600 cycles later.
  - tx_full never blocks a write, because the first pop frees a slot.
- Overflow: with the FSM busy, write 6 words.
  - tx_full rises after the 4th queued word.
  - Extra words are dropped.
  - Exactly 1+4 words are transmitted.
- Divisor edge: divisor=0 and divisor=1.
  - Each bit lasts 16 cycles.
  - divisor=2047 gives 32,752-cycle bits.
- Reset mid-frame: assert reset during the DATA bits of byte 1.
  - tx=1 the next cycle and the FIFO is empty.
  - No further frames are sent.
